// File: rtl/park_pkg.sv
// rtl/park_pkg.sv - shared gate controller state type and beam encodings
package park_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENT_A,
    ST_ENT_AB,
    ST_ENT_B,
    ST_EXT_B,
    ST_EXT_BA,
    ST_EXT_A,
    ST_WAIT_CLEAR
  } gate_state_t;

  // Beam pair encoded as {a, b}
  localparam logic [1:0] BEAM_CLEAR  = 2'b00;
  localparam logic [1:0] BEAM_B_ONLY = 2'b01;
  localparam logic [1:0] BEAM_A_ONLY = 2'b10;
  localparam logic [1:0] BEAM_BOTH   = 2'b11;

  function automatic logic lane_active(input gate_state_t s);
    return (s != ST_IDLE) && (s != ST_WAIT_CLEAR);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchronizer followed by a hold-time debouncer
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      count  <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      // Flip on the DEBOUNCE_CYCLES-th consecutive differing sample
      if (sync_2 == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        count <= '0;
        level <= sync_2;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gate_controller.sv
// rtl/gate_controller.sv - lane barrier FSM turning beam-break order into entry/exit pulses
module gate_controller
  import park_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_a,
  input  logic sensor_b,
  input  logic full,
  output logic car_in,
  output logic car_out,
  output logic barrier_open,
  output logic reject,
  output logic timeout
);

  localparam int TMAX = (TIMEOUT_CYCLES > DEBOUNCE_CYCLES + 2) ? TIMEOUT_CYCLES : DEBOUNCE_CYCLES + 2;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] CLEAR_LAST   = TW'(DEBOUNCE_CYCLES + 1);

  logic a;
  logic b;
  logic [1:0] beam;

  gate_state_t state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic car_in_next, car_out_next, reject_next, timeout_next;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (sensor_a),
    .level (a)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (sensor_b),
    .level (b)
  );

  assign beam = {a, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_WAIT_CLEAR;
      timer        <= '0;
      car_in       <= 1'b0;
      car_out      <= 1'b0;
      reject       <= 1'b0;
      timeout      <= 1'b0;
      barrier_open <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      car_in       <= car_in_next;
      car_out      <= car_out_next;
      reject       <= reject_next;
      timeout      <= timeout_next;
      barrier_open <= lane_active(state_next);
    end
  end

  always_comb begin
    state_next   = state;
    timer_next   = timer;
    car_in_next  = 1'b0;
    car_out_next = 1'b0;
    reject_next  = 1'b0;
    timeout_next = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_next = '0;
        // Hold one cycle after a completion so pulses never land back to back
        if (!(car_in || car_out)) begin
          case (beam)
            BEAM_A_ONLY: begin
              if (full) begin
                state_next  = ST_WAIT_CLEAR;
                reject_next = 1'b1;
              end else begin
                state_next = ST_ENT_A;
              end
            end
            BEAM_B_ONLY: state_next = ST_EXT_B;
            BEAM_BOTH:   state_next = ST_WAIT_CLEAR;
            default:     state_next = ST_IDLE;
          endcase
        end
      end

      ST_WAIT_CLEAR: begin
        if (beam != BEAM_CLEAR) begin
          timer_next = '0;
        end else if (timer == CLEAR_LAST) begin
          timer_next = '0;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end

      default: begin
        case (state)
          ST_ENT_A: begin
            if (beam == BEAM_BOTH)       state_next = ST_ENT_AB;
            else if (beam == BEAM_CLEAR) state_next = ST_IDLE;
          end
          ST_ENT_AB: begin
            if (beam == BEAM_B_ONLY)      state_next = ST_ENT_B;
            else if (beam == BEAM_A_ONLY) state_next = ST_ENT_A;
          end
          ST_ENT_B: begin
            if (beam == BEAM_CLEAR) begin
              state_next  = ST_IDLE;
              car_in_next = 1'b1;
            end else if (beam == BEAM_BOTH) begin
              state_next = ST_ENT_AB;
            end
          end
          ST_EXT_B: begin
            if (beam == BEAM_BOTH)       state_next = ST_EXT_BA;
            else if (beam == BEAM_CLEAR) state_next = ST_IDLE;
          end
          ST_EXT_BA: begin
            if (beam == BEAM_A_ONLY)      state_next = ST_EXT_A;
            else if (beam == BEAM_B_ONLY) state_next = ST_EXT_B;
          end
          ST_EXT_A: begin
            if (beam == BEAM_CLEAR) begin
              state_next   = ST_IDLE;
              car_out_next = 1'b1;
            end else if (beam == BEAM_BOTH) begin
              state_next = ST_EXT_BA;
            end
          end
          default: state_next = ST_WAIT_CLEAR;
        endcase

        if (state_next != state) begin
          timer_next = '0;
        end else if (timer == TIMEOUT_LAST) begin
          state_next   = ST_WAIT_CLEAR;
          timer_next   = '0;
          timeout_next = 1'b1;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_gate_controller.sv
// tb/tb_gate_controller.sv - scoreboard bench for gate_controller
module tb_gate_controller;

  localparam int DEB  = 4;
  localparam int TOUT = 32;
  localparam int LAT  = DEB + 3;

  localparam logic [3:0] K_IN      = 4'b1000;
  localparam logic [3:0] K_OUT     = 4'b0100;
  localparam logic [3:0] K_REJECT  = 4'b0010;
  localparam logic [3:0] K_TIMEOUT = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sensor_a, sensor_b, full;
  logic car_in, car_out, barrier_open, reject, timeout;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  gate_controller #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_a     (sensor_a),
    .sensor_b     (sensor_b),
    .full         (full),
    .car_in       (car_in),
    .car_out      (car_out),
    .barrier_open (barrier_open),
    .reject       (reject),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse the DUT emits must match the oldest expected event, kind and cycle
  always @(negedge clk) begin
    logic [3:0] got;
    exp_t e;
    got = {car_in, car_out, reject, timeout};
    if (got !== 4'b0000 && !rst) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse got=%b cycle=%0d expected none", got, cyc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e.kind || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL pulse got=%b@%0d expected=%b@%0d", got, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beams(input logic a_v, input logic b_v);
    sensor_a = a_v;
    sensor_b = b_v;
  endtask

  task automatic expect_pulse(input logic [3:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_pulses got=%0d outstanding expected=0 next_kind=%b next_cyc=%0d",
               name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    beams(1'b0, 1'b0);
    full = 1'b0;
    tick(3);
    vectors++;
    if ({car_in, car_out, barrier_open, reject, timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b expected=00000",
               {car_in, car_out, barrier_open, reject, timeout});
    end
    rst = 1'b0;
    tick(12);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_barrier got=%b expected=0", barrier_open);
    end
  endtask

  task automatic test_clean_entry();
    full = 1'b0;
    beams(1'b1, 1'b0);
    tick(LAT - 1);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_barrier_early got=%b expected=0", barrier_open);
    end
    tick(1);
    vectors++;
    if (barrier_open !== 1'b1) begin
      miscompares++;
      $display("FAIL entry_barrier_rise got=%b expected=1", barrier_open);
    end
    tick(10 - LAT);
    beams(1'b1, 1'b1);
    tick(10);
    beams(1'b0, 1'b1);
    tick(10);
    beams(1'b0, 1'b0);
    expect_pulse(K_IN, cyc + LAT);
    tick(LAT - 1);
    vectors++;
    if (barrier_open !== 1'b1) begin
      miscompares++;
      $display("FAIL entry_barrier_hold got=%b expected=1", barrier_open);
    end
    tick(1);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_barrier_fall got=%b expected=0", barrier_open);
    end
    tick(12);
    check_drained("clean_entry");
  endtask

  task automatic test_exit_full();
    full = 1'b1;
    beams(1'b0, 1'b1);
    tick(10);
    vectors++;
    if (barrier_open !== 1'b1) begin
      miscompares++;
      $display("FAIL exit_barrier got=%b expected=1", barrier_open);
    end
    beams(1'b1, 1'b1);
    tick(10);
    beams(1'b1, 1'b0);
    tick(10);
    beams(1'b0, 1'b0);
    expect_pulse(K_OUT, cyc + LAT);
    tick(15);
    check_drained("exit_full");
  endtask

  task automatic test_full_reject();
    int seen_open;
    full = 1'b1;
    seen_open = 0;
    beams(1'b1, 1'b0);
    expect_pulse(K_REJECT, cyc + LAT);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (barrier_open === 1'b1) seen_open++;
    end
    vectors++;
    if (seen_open != 0) begin
      miscompares++;
      $display("FAIL reject_barrier got=%0d open cycles expected=0", seen_open);
    end
    // Re-arm A so its debounced rise lands on the first IDLE cycle after WAIT_CLEAR
    beams(1'b0, 1'b0);
    full = 1'b0;
    tick(DEB + 2);
    beams(1'b1, 1'b0);
    tick(LAT);
    vectors++;
    if (barrier_open !== 1'b1) begin
      miscompares++;
      $display("FAIL reject_idle_timing got=%b expected=1", barrier_open);
    end
    beams(1'b0, 1'b0);
    tick(12);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_backout got=%b expected=0", barrier_open);
    end
    check_drained("full_reject");
  endtask

  task automatic test_bounce_backout();
    int seen_open;
    full = 1'b0;
    seen_open = 0;
    for (int g = 0; g < 3; g++) begin
      beams(1'b1, 1'b0);
      tick(2);
      beams(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        tick(1);
        if (barrier_open === 1'b1) seen_open++;
      end
    end
    vectors++;
    if (seen_open != 0) begin
      miscompares++;
      $display("FAIL glitch_filter got=%0d open cycles expected=0", seen_open);
    end
    beams(1'b1, 1'b0);
    tick(10);
    beams(1'b1, 1'b1);
    tick(10);
    vectors++;
    if (barrier_open !== 1'b1) begin
      miscompares++;
      $display("FAIL backout_open got=%b expected=1", barrier_open);
    end
    beams(1'b1, 1'b0);
    tick(10);
    beams(1'b0, 1'b0);
    tick(12);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL backout_closed got=%b expected=0", barrier_open);
    end
    check_drained("bounce_backout");
  endtask

  task automatic test_stall();
    full = 1'b0;
    beams(1'b1, 1'b0);
    tick(10);
    beams(1'b1, 1'b1);
    expect_pulse(K_TIMEOUT, cyc + LAT + TOUT);
    tick(LAT + TOUT);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_barrier got=%b expected=0", barrier_open);
    end
    tick(50 - LAT - TOUT);
    beams(1'b0, 1'b1);
    tick(10);
    beams(1'b0, 1'b0);
    tick(20);
    check_drained("stall");
  endtask

  task automatic test_reset_mid_entry();
    full = 1'b0;
    beams(1'b1, 1'b0);
    tick(10);
    beams(1'b1, 1'b1);
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_barrier got=%b expected=0", barrier_open);
    end
    beams(1'b0, 1'b0);
    tick(20);
    beams(1'b1, 1'b1);
    tick(12);
    vectors++;
    if (barrier_open !== 1'b0) begin
      miscompares++;
      $display("FAIL both_at_once got=%b expected=0", barrier_open);
    end
    beams(1'b0, 1'b0);
    tick(20);
    check_drained("reset_mid_entry");
  endtask

  task automatic test_back_to_back();
    full = 1'b0;
    beams(1'b1, 1'b0);
    tick(6);
    beams(1'b1, 1'b1);
    tick(6);
    beams(1'b0, 1'b1);
    tick(6);
    beams(1'b0, 1'b0);
    expect_pulse(K_IN, cyc + LAT);
    tick(12);
    beams(1'b0, 1'b1);
    tick(6);
    beams(1'b1, 1'b1);
    tick(6);
    beams(1'b1, 1'b0);
    tick(6);
    beams(1'b0, 1'b0);
    expect_pulse(K_OUT, cyc + LAT);
    tick(15);
    check_drained("back_to_back");
  endtask

  initial begin
    test_reset();
    test_clean_entry();
    test_exit_full();
    test_full_reject();
    test_bounce_backout();
    test_stall();
    test_reset_mid_entry();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
